// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, line levels and sizing helper for the UART TX scheduler.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   // Index width for n items, never narrower than one bit.
   function automatic int grant_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick, searching upward from ptr_i+1 with wrap.
module uart_rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = grant_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      gnt_idx_o
);

   logic          found;
   logic [IW-1:0] cand;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IW'((int'(ptr_i) + k) % NUM_REQ);
         if (en_i && !found && req_i[cand]) begin
            found        = 1'b1;
            gnt_idx_o    = cand;
            gnt_o[cand]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin shared UART transmitter framed on an external baud_tick.
// Optional macro UART_TX_PARITY_EN appends an even-parity bit after the data bits.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        baud_tick,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        tx,
   output logic                        busy,
   output logic [grant_w(NUM_REQ)-1:0] grant_id,
   output tx_state_e                   dbg_state_o
);

   localparam int GW = grant_w(NUM_REQ);
   localparam int CW = grant_w(DATA_W);

   tx_state_e          state_q, state_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic [GW-1:0]      grant_q, grant_d;
   logic [GW-1:0]      ptr_q, ptr_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
   logic               stop_cnt_q, stop_cnt_d;
   logic [NUM_REQ-1:0] gnt;
   logic [GW-1:0]      gnt_idx;
   logic [DATA_W-1:0]  req_byte;
   logic               arb_en;
`ifdef UART_TX_PARITY_EN
   logic               parity_q, parity_d;
`endif

   // Handshake: a byte transfers in the single cycle where req_valid[i] and req_ready[i]
   // are both high; req_ready is a one-cycle pulse, only in IDLE, and only outside reset.
   assign arb_en = (state_q == IDLE) && rst_n;

   uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i     (req_valid),
      .ptr_i     (ptr_q),
      .en_i      (arb_en),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   assign req_byte    = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
   assign req_ready   = gnt;
   assign tx          = tx_q;
   assign busy        = busy_q;
   assign grant_id    = grant_q;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               shift_d  = req_byte;
               grant_d  = gnt_idx;
               ptr_d    = gnt_idx;
               busy_d   = 1'b1;
               state_d  = ARM;
`ifdef UART_TX_PARITY_EN
               parity_d = ^req_byte;
`endif
            end
         end
         ARM: begin
            tx_d = IDLE_LEVEL;
            if (baud_tick) begin
               tx_d    = START_LEVEL;
               state_d = START;
            end
         end
         START: begin
            if (baud_tick) begin
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (bit_cnt_q == CW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                  tx_d       = parity_q;
                  state_d    = PARITY;
`else
                  tx_d       = IDLE_LEVEL;
                  stop_cnt_d = 1'b0;
                  state_d    = STOP;
`endif
               end else begin
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_tick) begin
               tx_d       = IDLE_LEVEL;
               stop_cnt_d = 1'b0;
               state_d    = STOP;
            end
         end
`endif
         STOP: begin
            tx_d = IDLE_LEVEL;
            if (baud_tick) begin
               if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_q       <= IDLE_LEVEL;
         busy_q     <= 1'b0;
         grant_q    <= '0;
         ptr_q      <= GW'(NUM_REQ - 1);
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_q <= 1'b0;
      else        parity_q <= parity_d;
   end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized bench with a tick-counting frame model, plus directed frames.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_scheduler;
   import uart_pkg::*;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 8;
   localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL = 1 + DATA_W + PAR + STOP_BITS;

   // clock / reset / stimulus signals
   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      baud_tick;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      tx, busy;
   logic [1:0]                grant_id;
   tx_state_e                 dbg_state;

   logic [1:0]  req_valid2;
   logic [15:0] req_data2;
   logic [1:0]  req_ready2;
   logic        tx2, busy2;
   logic [0:0]  grant_id2;
   tx_state_e   dbg_state2;

   int n_chk = 0;
   int n_fail = 0;
   int tick_gap = 16;
   int tick_cnt = 0;
   bit rand_mode = 0;
   bit cmp_en = 0;
   bit rr_en = 0;
   bit chk2_en = 0;
   int rdy_cnt = 0;
   int seen[16];

   // behavioural model: frame progress counted in baud ticks since accept
   bit                 m_busy;
   int                 m_t, m_g, m_ptr;
   logic [DATA_W-1:0]  m_byte;
   logic [NUM_REQ-1:0] m_acc;
   int                 grants_q[$];

   uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .STOP_BITS(STOP_BITS)) u_dut (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .req_valid(req_valid),
      .req_data(req_data), .req_ready(req_ready), .tx(tx), .busy(busy),
      .grant_id(grant_id), .dbg_state_o(dbg_state)
   );

   uart_tx_scheduler #(.NUM_REQ(2), .DATA_W(8), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .req_valid(req_valid2),
      .req_data(req_data2), .req_ready(req_ready2), .tx(tx2), .busy(busy2),
      .grant_id(grant_id2), .dbg_state_o(dbg_state2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input int ptr, input logic [NUM_REQ-1:0] v);
      for (int k = 1; k <= NUM_REQ; k++)
         if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      return -1;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input int g);
      logic [NUM_REQ-1:0] r;
      r = '0;
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   function automatic logic [NUM_REQ-1:0] exp_ready();
      if (!rst_n || m_busy) return '0;
      return onehot(pick(m_ptr, req_valid));
   endfunction

   function automatic logic exp_tx();
      if (!m_busy || m_t == 0) return 1'b1;
      if (m_t == 1) return 1'b0;
      if (m_t <= DATA_W + 1) return m_byte[m_t-2];
      if (PAR == 1 && m_t == DATA_W + 2) return ^m_byte;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_t    <= 0;
         m_g    <= 0;
         m_ptr  <= NUM_REQ - 1;
         m_byte <= '0;
         m_acc  <= '0;
      end else begin
         m_acc <= '0;
         if (!m_busy) begin
            if (pick(m_ptr, req_valid) >= 0) begin
               m_acc  <= onehot(pick(m_ptr, req_valid));
               m_g    <= pick(m_ptr, req_valid);
               m_ptr  <= pick(m_ptr, req_valid);
               m_byte <= req_data[pick(m_ptr, req_valid)*DATA_W +: DATA_W];
               m_busy <= 1'b1;
               m_t    <= 0;
               grants_q.push_back(pick(m_ptr, req_valid));
            end
         end else if (baud_tick) begin
            m_t <= m_t + 1;
            if (m_t == FL) m_busy <= 1'b0;
         end
      end
   end

   // scoreboard compare, every cycle, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("tx", tx, exp_tx());
         chk("busy", busy, m_busy);
         chk("req_ready", req_ready, exp_ready());
         chk("grant_id", grant_id, m_g);
         chk("idle_state", dbg_state == IDLE, !m_busy);
      end
      if (rr_en) rdy_cnt += $countones(req_ready);
      if (chk2_en) chk("s2_ready_while_busy", busy2 && (req_ready2 != 2'b00), 1'b0);
   end

   // baud tick generator
   initial begin
      forever begin
         @(posedge clk); #1;
         if (tick_cnt >= tick_gap - 1) begin
            baud_tick = 1'b1;
            tick_cnt  = 0;
         end else begin
            baud_tick = 1'b0;
            tick_cnt++;
         end
      end
   end

   // random requester driver
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_mode) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (m_acc[i]) begin
                  req_valid[i] = ($urandom_range(0, 2) != 0);
                  req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
               end else if (!req_valid[i]) begin
                  if ($urandom_range(0, 7) == 0) begin
                     req_valid[i] = 1'b1;
                     req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                  end
               end else if ($urandom_range(0, 63) == 0) begin
                  req_valid[i] = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_busy && n < 5000) begin @(negedge clk); n++; end
      chk("wait_idle_budget", n < 5000, 1'b1);
   endtask

   task automatic wait_tick();
      int n = 0;
      while (!baud_tick && n < 200) begin @(negedge clk); n++; end
      chk("wait_tick_budget", n < 200, 1'b1);
   endtask

   // One directed frame on the main DUT; tx after each tick lands in seen[].
   task automatic run_frame(input int r, input logic [DATA_W-1:0] b);
      wait_idle();
      step();
      req_data[r*DATA_W +: DATA_W] = b;
      req_valid = onehot(r);
      @(negedge clk);
      chk("frm_ready", req_ready, onehot(r));
      step();
      req_valid = '0;
      @(negedge clk);
      chk("frm_ready_pulse", req_ready, '0);
      chk("frm_grant", grant_id, r);
      chk("frm_busy", busy, 1'b1);
      for (int k = 0; k < FL; k++) begin
         wait_tick();
         @(negedge clk);
         seen[k] = int'(tx);
      end
      chk("frm_busy_last", busy, 1'b1);
      wait_tick();
      @(negedge clk);
      chk("frm_busy_end", busy, 1'b0);
   endtask

   int sf_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
   int s2_seq[11] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
   int rr_seq[5]  = '{0, 1, 2, 3, 0};

   initial begin
      rst_n = 1'b0; baud_tick = 1'b0;
      req_valid = '0; req_data = '0; req_valid2 = '0; req_data2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", req_ready, '0);
      chk("rst_grant", grant_id, 2'd0);
      chk("rst_tx2", tx2, 1'b1);
      step();
      rst_n = 1'b1;
      cmp_en = 1'b1;
      tick_gap = 4;

      // idle line across 20 ticks
      repeat (80) @(negedge clk);
      chk("idle_tx", tx, 1'b1);
      chk("idle_fsm", dbg_state == IDLE, 1'b1);

      // round robin with all requesters valid
      step();
      grants_q.delete();
      rr_en = 1'b1;
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      req_valid = '1;
      for (int n = 0; n < 3000 && grants_q.size() < 5; n++) step();
      req_valid = '0;
      rr_en = 1'b0;
      chk("rr_count", grants_q.size(), 5);
      for (int k = 0; k < 5; k++)
         if (k < grants_q.size()) chk("rr_order", grants_q[k], rr_seq[k]);
      chk("rr_ready_pulses", rdy_cnt, 5);

      // single frame 0xA5 from requester 2
      tick_gap = 16;
      run_frame(2, 8'hA5);
      for (int k = 0; k < 9; k++) chk("sf_tx", seen[k], sf_seq[k]);
      chk("sf_stop", seen[FL-1], 1);
`ifdef UART_TX_PARITY_EN
      chk("sf_parity", seen[9], 0);
      run_frame(1, 8'h07);
      chk("par_07", seen[9], 1);
      chk("par_07_stop", seen[10], 1);
      run_frame(3, 8'h03);
      chk("par_03", seen[9], 0);
`endif

      // reset during data bit 3
      wait_idle();
      tick_gap = 4;
      step();
      req_data[7:0] = 8'h3C;
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      begin
         int n = 0;
         while (!(m_busy && m_t == 5) && n < 500) begin @(negedge clk); n++; end
         chk("mr_reach_bit3", n < 500, 1'b1);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_tx", tx, 1'b1);
      chk("mr_busy", busy, 1'b0);
      chk("mr_fsm", dbg_state == IDLE, 1'b1);
      step();
      req_valid = '1;
      @(negedge clk);
      chk("mr_ready_in_reset", req_ready, '0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("mr_regrant", req_ready, 4'b0001);
      step();
      req_valid = '0;

      // randomized traffic with varying tick spacing
      wait_idle();
      rand_mode = 1'b1;
      repeat (4000) begin
         step();
         if ($urandom_range(0, 99) == 0) tick_gap = $urandom_range(2, 6);
      end
      rand_mode = 1'b0;
      req_valid = '0;
      wait_idle();

      // two stop bits at minimum tick spacing
      tick_gap = 2;
      chk2_en = 1'b1;
      step();
      chk("s2_idle", dbg_state2 == IDLE, 1'b1);
      req_data2 = {8'h5A, 8'h5A};
      req_valid2 = 2'b11;
      @(negedge clk);
      chk("s2_ready", req_ready2, 2'b01);
      step();
      req_valid2 = 2'b10;
      for (int k = 0; k < 11; k++) begin
         wait_tick();
         @(negedge clk);
         chk("s2_tx", tx2, s2_seq[k]);
      end
      chk("s2_busy_last", busy2, 1'b1);
      wait_tick();
      @(negedge clk);
      chk("s2_busy_end", busy2, 1'b0);
      chk("s2_next_ready", req_ready2, 2'b10);
      step();
      req_valid2 = '0;
      @(negedge clk);
      chk("s2_grant1", grant_id2, 1'b1);
      repeat (40) @(negedge clk);
      chk2_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
